shot_fire_controller: RTL and testbench

//  Upstream of the shot mover: converts player fire/steer keys into a one-cycle triggerShot pulse plus

---
 rtl/shot_fire_controller_if.sv | 24 ++
 rtl/shot_fire_controller.sv | 155 +++++++++++++++
 tb/tb_shot_fire_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shot_fire_controller_if.sv
// Player-input / mover-handshake / HUD bundle for the shot fire controller.
// The game side (keys, frame strobe, mover ready) is the master; the controller is the slave.
interface shot_fire_controller_if;
    logic       startOfFrame;
    logic       fireKey;
    logic       leftKey;
    logic       rightKey;
    logic       shotReady;
    logic       pause;
    logic       triggerShot;
    logic [2:0] shotDirection;
    logic [3:0] ammoCount;
    logic       reloading;

    modport master (
        output startOfFrame, fireKey, leftKey, rightKey, shotReady, pause,
        input  triggerShot, shotDirection, ammoCount, reloading
    );

    modport slave (
        input  startOfFrame, fireKey, leftKey, rightKey, shotReady, pause,
        output triggerShot, shotDirection, ammoCount, reloading
    );
endinterface

// File: rtl/shot_fire_controller.sv
// Turns fire/steer keys into a one-clock triggerShot pulse with a direction code, enforcing
// a per-shot cooldown and a magazine reload, both counted in frames.
module shot_fire_controller #(
    parameter int MAX_AMMO        = 8,
    parameter int COOLDOWN_FRAMES = 6,
    parameter int RELOAD_FRAMES   = 60,
    parameter int AUTO_FIRE       = 0,
    parameter int ACK_TIMEOUT     = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    shot_fire_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_ACK,
        COOLDOWN,
        RELOAD
    } state_t;

    localparam logic [3:0] AMMO_FULL = 4'(MAX_AMMO);
    localparam logic [7:0] CD_INIT   = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0] RL_INIT   = 8'(RELOAD_FRAMES);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [2:0] DIR_LEFT     = 3'b100;
    localparam logic [2:0] DIR_STRAIGHT = 3'b010;
    localparam logic [2:0] DIR_RIGHT    = 3'b001;

    state_t     state, state_next;
    logic       fire_key_d;
    logic [7:0] ack_cnt, ack_next;
    logic [7:0] cd_cnt, cd_next;
    logic [7:0] rl_cnt, rl_next;
    logic [3:0] ammo, ammo_next;
    logic [2:0] dir, dir_next;
    logic       trigger_q, trigger_next;
    logic       reloading_q, reloading_next;

    logic fire_edge;
    logic fire_req;
    logic frame_tick;
    logic [2:0] dir_decoded;

    assign fire_edge  = bus.fireKey & ~fire_key_d;
    assign fire_req   = (AUTO_FIRE != 0) ? bus.fireKey : fire_edge;
    assign frame_tick = bus.startOfFrame & ~bus.pause;

    always_comb begin
        case ({bus.leftKey, bus.rightKey})
            2'b10:   dir_decoded = DIR_LEFT;
            2'b01:   dir_decoded = DIR_RIGHT;
            default: dir_decoded = DIR_STRAIGHT;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_next     = state;
        ack_next       = ack_cnt;
        cd_next        = cd_cnt;
        rl_next        = rl_cnt;
        ammo_next      = ammo;
        dir_next       = dir;
        trigger_next   = 1'b0;
        reloading_next = reloading_q;

        case (state)
            IDLE: begin
                if (fire_req && bus.shotReady && !bus.pause && ammo != 4'd0) begin
                    state_next = FIRE;
                    dir_next   = dir_decoded;
                end
            end

            FIRE: begin
                trigger_next = 1'b1;
                if (ammo != 4'd0) ammo_next = ammo - 4'd1;
                ack_next   = 8'd0;
                state_next = WAIT_ACK;
            end

            // A mover that never drops shotReady must not stall us; the shot is spent either way.
            WAIT_ACK: begin
                if (!bus.shotReady || ack_cnt == ACK_LAST) begin
                    state_next = COOLDOWN;
                    cd_next    = CD_INIT;
                end else begin
                    ack_next = ack_cnt + 8'd1;
                end
            end

            COOLDOWN: begin
                if (cd_cnt == 8'd0 || (frame_tick && cd_cnt == 8'd1)) begin
                    cd_next = 8'd0;
                    if (ammo != 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        state_next     = RELOAD;
                        rl_next        = RL_INIT;
                        reloading_next = 1'b1;
                    end
                end else if (frame_tick) begin
                    cd_next = cd_cnt - 8'd1;
                end
            end

            RELOAD: begin
                if (rl_cnt == 8'd0 || (frame_tick && rl_cnt == 8'd1)) begin
                    rl_next        = 8'd0;
                    ammo_next      = AMMO_FULL;
                    reloading_next = 1'b0;
                    state_next     = IDLE;
                end else if (frame_tick) begin
                    rl_next = rl_cnt - 8'd1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            fire_key_d  <= 1'b0;
            ack_cnt     <= 8'd0;
            cd_cnt      <= 8'd0;
            rl_cnt      <= 8'd0;
            ammo        <= AMMO_FULL;
            dir         <= DIR_STRAIGHT;
            trigger_q   <= 1'b0;
            reloading_q <= 1'b0;
        end else begin
            state       <= state_next;
            fire_key_d  <= bus.fireKey;
            ack_cnt     <= ack_next;
            cd_cnt      <= cd_next;
            rl_cnt      <= rl_next;
            ammo        <= ammo_next;
            dir         <= dir_next;
            trigger_q   <= trigger_next;
            reloading_q <= reloading_next;
        end
    end

    assign bus.triggerShot   = trigger_q;
    assign bus.shotDirection = dir;
    assign bus.ammoCount     = ammo;
    assign bus.reloading     = reloading_q;

endmodule

// File: tb/tb_shot_fire_controller.sv
// Directed bench for shot_fire_controller: one single-shot instance and one auto-fire instance,
// driven on the falling edge and sampled on the falling edge; frames are 8 clocks long.
module tb_shot_fire_controller;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    shot_fire_controller_if bus_a ();
    shot_fire_controller_if bus_b ();

    shot_fire_controller #(.AUTO_FIRE(0)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_a)
    );

    shot_fire_controller #(.AUTO_FIRE(1)) dut_auto (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int trig_a   = 0;
    int trig_b   = 0;

    // Pulses are counted at the rising edge, where the flop output still shows the previous cycle.
    always @(posedge clk) begin
        if (bus_a.triggerShot === 1'b1) trig_a++;
        if (bus_b.triggerShot === 1'b1) trig_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame();
        bus_a.startOfFrame = 1'b1;
        bus_b.startOfFrame = 1'b1;
        tick();
        bus_a.startOfFrame = 1'b0;
        bus_b.startOfFrame = 1'b0;
        repeat (7) tick();
    endtask

    // One acknowledged shot on instance A followed by a full cooldown.
    task automatic fire_shot(input int i, input logic [3:0] exp_ammo);
        logic [2:0] exp_dir;
        case (i % 3)
            0:       begin bus_a.leftKey = 1'b1; bus_a.rightKey = 1'b0; exp_dir = 3'b100; end
            1:       begin bus_a.leftKey = 1'b0; bus_a.rightKey = 1'b1; exp_dir = 3'b001; end
            default: begin bus_a.leftKey = 1'b1; bus_a.rightKey = 1'b1; exp_dir = 3'b010; end
        endcase
        bus_a.fireKey = 1'b1;
        tick();
        tick();
        check($sformatf("shot%0d_trig", i), bus_a.triggerShot, 1'b1);
        check($sformatf("shot%0d_dir", i), bus_a.shotDirection, exp_dir);
        check($sformatf("shot%0d_ammo", i), bus_a.ammoCount, exp_ammo);
        bus_a.shotReady = 1'b0;
        tick();
        bus_a.shotReady = 1'b1;
        bus_a.fireKey   = 1'b0;
        bus_a.leftKey   = 1'b0;
        bus_a.rightKey  = 1'b0;
        repeat (6) frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_a.startOfFrame = 1'b0; bus_a.fireKey = 1'b0; bus_a.leftKey = 1'b0;
        bus_a.rightKey = 1'b0; bus_a.shotReady = 1'b1; bus_a.pause = 1'b0;
        bus_b.startOfFrame = 1'b0; bus_b.fireKey = 1'b0; bus_b.leftKey = 1'b0;
        bus_b.rightKey = 1'b0; bus_b.shotReady = 1'b1; bus_b.pause = 1'b0;
        resetN = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_trig", bus_a.triggerShot, 1'b0);
        check("rst_dir", bus_a.shotDirection, 3'b010);
        check("rst_ammo", bus_a.ammoCount, 4'd8);
        check("rst_reloading", bus_a.reloading, 1'b0);
        check("rst_ammo_auto", bus_b.ammoCount, 4'd8);
        resetN = 1'b1;
        tick();

        // First shot: left key, mover never acknowledges, key held for 20 frames.
        bus_a.leftKey = 1'b1;
        bus_a.fireKey = 1'b1;
        tick();
        check("lat_edge1", bus_a.triggerShot, 1'b0);
        tick();
        check("lat_edge2_trig", bus_a.triggerShot, 1'b1);
        check("first_dir", bus_a.shotDirection, 3'b100);
        check("first_ammo", bus_a.ammoCount, 4'd7);
        bus_a.leftKey = 1'b0;
        tick();
        check("trig_one_clock", bus_a.triggerShot, 1'b0);
        check("dir_held", bus_a.shotDirection, 3'b100);
        check("ack_cnt_1", dut.ack_cnt, 8'd1);
        tick();
        tick();
        check("ack_cnt_3", dut.ack_cnt, 8'd3);
        check("cd_not_loaded", dut.cd_cnt, 8'd0);
        tick();
        check("timeout_cd_load", dut.cd_cnt, 8'd6);
        check("timeout_ammo", bus_a.ammoCount, 4'd7);

        repeat (2) frame();
        check("cd_after_2", dut.cd_cnt, 8'd4);
        bus_a.pause = 1'b1;
        repeat (10) frame();
        check("cd_paused", dut.cd_cnt, 8'd4);
        bus_a.pause = 1'b0;
        repeat (3) frame();
        check("cd_resumed", dut.cd_cnt, 8'd1);
        frame();
        check("cd_done", dut.cd_cnt, 8'd0);
        repeat (4) frame();
        check("hold_single_shot", trig_a, 1);
        bus_a.fireKey = 1'b0;
        tick();

        // Pause and a busy mover both block IDLE->FIRE; a held key is not replayed afterwards.
        bus_a.pause   = 1'b1;
        bus_a.fireKey = 1'b1;
        repeat (3) tick();
        check("pause_blocks", trig_a, 1);
        bus_a.fireKey = 1'b0;
        bus_a.pause   = 1'b0;
        tick();
        bus_a.shotReady = 1'b0;
        bus_a.fireKey   = 1'b1;
        repeat (2) tick();
        bus_a.shotReady = 1'b1;
        repeat (3) tick();
        check("edge_not_buffered", trig_a, 1);
        check("blocked_ammo", bus_a.ammoCount, 4'd7);
        bus_a.fireKey = 1'b0;
        tick();

        // Empty the magazine.
        for (int i = 1; i < 8; i++) fire_shot(i, 4'(7 - i));
        check("empty_ammo", bus_a.ammoCount, 4'd0);
        check("empty_reloading", bus_a.reloading, 1'b1);

        bus_a.fireKey = 1'b1;
        repeat (4) tick();
        check("reload_fire_ignored", trig_a, 8);
        bus_a.fireKey = 1'b0;
        repeat (59) frame();
        check("reload_59_reloading", bus_a.reloading, 1'b1);
        check("reload_59_ammo", bus_a.ammoCount, 4'd0);
        frame();
        check("reload_done", bus_a.reloading, 1'b0);
        check("reload_ammo", bus_a.ammoCount, 4'd8);

        // Empty it again, then reset asynchronously part-way through the reload.
        for (int i = 0; i < 8; i++) fire_shot(i, 4'(7 - i));
        check("second_reloading", bus_a.reloading, 1'b1);
        repeat (5) frame();
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_ammo", bus_a.ammoCount, 4'd8);
        check("async_rst_reloading", bus_a.reloading, 1'b0);
        check("async_rst_dir", bus_a.shotDirection, 3'b010);
        @(negedge clk);
        resetN = 1'b1;
        tick();

        // Auto-fire instance: held key re-fires once per cooldown.
        bus_b.fireKey = 1'b1;
        tick();
        tick();
        check("auto_first_trig", bus_b.triggerShot, 1'b1);
        check("auto_first_ammo", bus_b.ammoCount, 4'd7);
        repeat (4) tick();
        check("auto_cd_load", dut_auto.cd_cnt, 8'd6);
        repeat (18) frame();
        check("auto_trig_count", trig_b, 4);
        check("auto_ammo", bus_b.ammoCount, 4'd4);
        bus_b.fireKey = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
